// File: rtl/cla_stream_ctrl_if.sv
// Stream handshake bundle for cla_stream_ctrl: the operand offer on the upstream side
// and the result drain on the downstream side.
interface cla_stream_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/cla_stream_ctrl.sv
// Credit-limited valid/ready wrapper around the stall-less 16-bit pipelined CLA.
// Optional macro CLA_STREAM_CNT_EN adds a 16-bit pop counter output issue_cnt.
module cla_stream_ctrl #(
    parameter int LATENCY = 7,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_stream_ctrl_if.slave   strm,
    output logic [15:0]        cla_a,
    output logic [15:0]        cla_b,
    output logic               cla_cin,
    input  logic [15:0]        cla_s,
    input  logic               cla_cout
`ifdef CLA_STREAM_CNT_EN
    ,
    output logic [15:0]        issue_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] vpipe;
    logic [IW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [16:0]        mem [DEPTH];

    logic issue;
    logic capture;
    logic pop;

    assign cla_a   = strm.in_a;
    assign cla_b   = strm.in_b;
    assign cla_cin = strm.in_cin;

    // Credit counts queued plus in-flight results, so a capture can never find the FIFO full.
    assign strm.in_ready  = (SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH);
    assign strm.out_valid = (fifo_count != '0);
    assign strm.out_sum   = mem[rd_ptr][15:0];
    assign strm.out_cout  = mem[rd_ptr][16];

    assign issue   = strm.in_valid & strm.in_ready;
    assign capture = vpipe[LATENCY-1];
    assign pop     = strm.out_valid & strm.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe    <= '0;
            inflight <= '0;
        end else begin
            vpipe <= {vpipe[LATENCY-2:0], issue};
            case ({issue, capture})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) begin
                mem[wr_ptr] <= {cla_cout, cla_s};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef CLA_STREAM_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (pop) begin
            issue_cnt <= issue_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cla_stream_ctrl.sv
// Directed bench for cla_stream_ctrl with a behavioural 7-stage CLA in the loop.
// Build with CLA_STREAM_CNT_EN defined to also exercise issue_cnt.
module tb_cla_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cla_a;
    logic [15:0] cla_b;
    logic        cla_cin;
    logic [15:0] cla_s;
    logic        cla_cout;
`ifdef CLA_STREAM_CNT_EN
    logic [15:0] issue_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cla_stream_ctrl_if bus ();

    cla_stream_ctrl #(.LATENCY(7), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strm     (bus),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_s    (cla_s),
        .cla_cout (cla_cout)
`ifdef CLA_STREAM_CNT_EN
        ,
        .issue_cnt(issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Unresettable adder pipeline: sampled at E0, result visible after E6 for capture at E7.
    logic [16:0] cla_pipe [7];
    always @(posedge clk) begin
        cla_pipe[0] <= {1'b0, cla_a} + {1'b0, cla_b} + {16'b0, cla_cin};
        for (int i = 1; i < 7; i++) cla_pipe[i] <= cla_pipe[i-1];
    end
    assign cla_s    = cla_pipe[6][15:0];
    assign cla_cout = cla_pipe[6][16];

    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_sum got %h want 0000", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_cout got %b want 0", bus.out_cout); end
`ifdef CLA_STREAM_CNT_EN
        checks++; if (issue_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_issue_cnt got %h want 0000", issue_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        drive_op(16'h55F5, 16'h5448, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int e = 0; e < 7; e++) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid after E%0d got %b want 0", e, bus.out_valid); end
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_E7 got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'hAA3D) begin errors++; $display("[TB] FAIL single_sum got %h want aa3d", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("[TB] FAIL single_cout got %b want 0", bus.out_cout); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_one_pop got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        drive_op(16'h2424, 16'h0449, 1'b1);
        @(negedge clk);
        drive_op(16'h2880, 16'h8241, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 6) begin errors++; $display("[TB] FAIL b2b_latency got %0d cycles after E1 want 6", n); end
        checks++; if (bus.out_sum !== 16'h286E || bus.out_cout !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first got %h/%b want 286e/0", bus.out_sum, bus.out_cout); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'hAAC1 || bus.out_cout !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second got v=%b %h/%b want v=1 aac1/0", bus.out_valid, bus.out_sum, bus.out_cout); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_carry_out();
        int n;
        @(negedge clk);
        drive_op(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL carry_timeout got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 16'h0000 || bus.out_cout !== 1'b1) begin errors++; $display("[TB] FAIL carry_result got %h/%b want 0000/1", bus.out_sum, bus.out_cout); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [15:0] op_a [10];
        logic [15:0] exp_sum [10];
        int issued;
        int recv;
        int n;
        op_a    = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                    16'h5000, 16'h6000, 16'h7000, 16'h8000, 16'h9000};
        exp_sum = '{16'h0F10, 16'h1F10, 16'h2F10, 16'h3F10, 16'h4F10,
                    16'h5F10, 16'h6F10, 16'h7F10, 16'h8F10, 16'h9F10};
        issued = 0;
        recv   = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (n = 0; n < 220; n++) begin
            if (n == 20) begin
                checks++; if (issued !== 4) begin errors++; $display("[TB] FAIL bp_issued got %0d want 4", issued); end
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stalled got %b want 0", bus.in_ready); end
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_full_valid got %b want 1", bus.out_valid); end
                bus.out_ready = 1'b1;
            end
            if (recv == 10) break;
            if (issued < 10) drive_op(op_a[issued], 16'h0F0F, 1'b1);
            else bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready) issued++;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_sum !== exp_sum[recv] || bus.out_cout !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_result[%0d] got %h/%b want %h/0", recv, bus.out_sum, bus.out_cout, exp_sum[recv]);
                end
                recv++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (recv !== 10) begin errors++; $display("[TB] FAIL bp_received got %0d want 10", recv); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        int stale;
        int n;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_op(16'hABC0 + 16'(k), 16'h1111, 1'b0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_queued got %b want 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_ready got %b want 1", bus.in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready got %b want 1", bus.in_ready); end
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL mid_stale got %0d cycles valid want 0", stale); end
        drive_op(16'h1234, 16'h4321, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 7) begin errors++; $display("[TB] FAIL mid_new_latency got %0d want 7", n); end
        checks++; if (bus.out_sum !== 16'h5556 || bus.out_cout !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_result got %h/%b want 5556/0", bus.out_sum, bus.out_cout); end
        @(negedge clk);
    endtask

`ifdef CLA_STREAM_CNT_EN
    task automatic test_issue_cnt();
        int issued;
        do_reset();
        bus.out_ready = 1'b1;
        issued = 0;
        for (int c = 0; c < 100 && issued < 5; c++) begin
            drive_op(16'h0100, 16'h0001, 1'b0);
            if (bus.in_ready) issued++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (issue_cnt !== 16'd5) begin errors++; $display("[TB] FAIL cnt_five got %0d want 5", issue_cnt); end
        force dut.issue_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.issue_cnt;
        drive_op(16'h0002, 16'h0003, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (issue_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL cnt_wrap got %h want 0000", issue_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_carry_out();
        test_backpressure();
        test_reset_mid();
`ifdef CLA_STREAM_CNT_EN
        test_issue_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
